// File: rtl/uart_ascii_tx.sv
// Free-running 8N1 UART source: endlessly transmits FIRST_CHAR..LAST_CHAR on TxD,
// with IDLE_BITS idle bit periods after each stop bit.
module uart_ascii_tx #(
  parameter int          BAUD_DIV   = 1041,
  parameter int          IDLE_BITS  = 4,
  parameter logic [7:0]  FIRST_CHAR = 8'h41,
  parameter logic [7:0]  LAST_CHAR  = 8'h5A
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       TxD,
  output logic [7:0] tx_char,
  output logic       busy
);

  localparam int               CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [3:0]       GAP_LAST = 4'(IDLE_BITS - 1);

  typedef enum logic [1:0] {
    S_START,
    S_DATA,
    S_STOP,
    S_GAP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       char_q, char_d;
  logic             txd_q, txd_d;
  logic             busy_q, busy_d;
  logic [7:0]       tx_char_q;
  logic             tick;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    tick      = (cnt_q == CNT_LAST);
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    char_d    = char_q;

    case (state_q)
      S_START: if (tick) begin
        state_d   = S_DATA;
        bit_idx_d = '0;
      end
      S_DATA: if (tick) begin
        if (bit_idx_q == 4'd7) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
        end else begin
          bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      S_STOP: if (tick) begin
        state_d   = (IDLE_BITS == 0) ? S_START : S_GAP;
        bit_idx_d = '0;
        char_d    = (char_q == LAST_CHAR) ? FIRST_CHAR : char_q + 8'd1;
      end
      S_GAP: if (tick) begin
        if (bit_idx_q == GAP_LAST) begin
          state_d   = S_START;
          bit_idx_d = '0;
        end else begin
          bit_idx_d = bit_idx_q + 4'd1;
        end
      end
      default: state_d = S_START;
    endcase
  end

  // Line level for the current state; registered one cycle later, so each bit
  // appears on TxD on the edge after the state change and lasts BAUD_DIV cycles.
  always_comb begin
    txd_d  = 1'b1;
    busy_d = (state_q != S_GAP);
    case (state_q)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = char_q[bit_idx_q[2:0]];
      default: txd_d = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_START;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      char_q    <= FIRST_CHAR;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
      tx_char_q <= FIRST_CHAR;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      char_q    <= char_d;
      txd_q     <= txd_d;
      busy_q    <= busy_d;
      tx_char_q <= char_q;
    end
  end

  assign TxD     = txd_q;
  assign busy    = busy_q;
  assign tx_char = tx_char_q;

endmodule

// File: tb/tb_uart_ascii_tx.sv
// Self-checking bench for uart_ascii_tx: a line decoder pops expected bytes
// from a scoreboard queue filled when each DUT is released from reset.
module tb_uart_ascii_tx;

  localparam int DEF_BAUD = 1041;
  localparam int DEF_IDLE = 4;

  logic clk;
  logic rst_a, rst_w, rst_z;
  logic txd_a, txd_w, txd_z;
  logic busy_a, busy_w, busy_z;
  logic [7:0] char_a, char_w, char_z;

  int cyc;
  int n_tests;
  int n_fail;
  logic [7:0] exp_q[$];

  uart_ascii_tx u_def (
    .clk(clk), .rst_n(rst_a), .TxD(txd_a), .tx_char(char_a), .busy(busy_a)
  );

  uart_ascii_tx #(.BAUD_DIV(4), .FIRST_CHAR(8'h30), .LAST_CHAR(8'h32)) u_wrap (
    .clk(clk), .rst_n(rst_w), .TxD(txd_w), .tx_char(char_w), .busy(busy_w)
  );

  uart_ascii_tx #(.BAUD_DIV(4), .IDLE_BITS(0)) u_zero (
    .clk(clk), .rst_n(rst_z), .TxD(txd_z), .tx_char(char_z), .busy(busy_z)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic get_txd(input int sel);
    case (sel)
      0:       return txd_a;
      1:       return txd_w;
      default: return txd_z;
    endcase
  endfunction

  function automatic logic get_busy(input int sel);
    case (sel)
      0:       return busy_a;
      1:       return busy_w;
      default: return busy_z;
    endcase
  endfunction

  function automatic logic [7:0] get_char(input int sel);
    case (sel)
      0:       return char_a;
      1:       return char_w;
      default: return char_z;
    endcase
  endfunction

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Decode n frames from DUT sel; rel is the cycle count at reset release.
  task automatic rx_frames(input int sel, input int baud, input int idle,
                           input int n, input int rel);
    int         prev;
    bit         found;
    logic [7:0] data;
    logic [7:0] exp_b;
    prev = 0;
    for (int f = 0; f < n; f++) begin
      found = 1'b0;
      for (int t = 0; t < (12 + idle) * baud * 2 && !found; t++) begin
        @(negedge clk);
        if (get_txd(sel) == 1'b0) found = 1'b1;
      end
      if (!found) begin
        check("start_timeout", get_txd(sel), 1'b0);
        return;
      end
      if (f == 0) check("first_start_cycle", cyc - rel, 1);
      else        check("frame_period", cyc - prev, (10 + idle) * baud);
      prev = cyc;
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", exp_q.size(), 1);
        return;
      end
      exp_b = exp_q.pop_front();

      wait_cycles(baud / 2);
      check("start_bit", get_txd(sel), 1'b0);
      check("busy_start", get_busy(sel), 1'b1);
      check("tx_char", get_char(sel), exp_b);
      for (int i = 0; i < 8; i++) begin
        wait_cycles(baud);
        data[i] = get_txd(sel);
      end
      wait_cycles(baud);
      check("stop_bit", get_txd(sel), 1'b1);
      check("busy_stop", get_busy(sel), 1'b1);
      check("data_byte", data, exp_b);
      for (int g = 0; g < idle; g++) begin
        wait_cycles(baud);
        check("gap_txd", get_txd(sel), 1'b1);
        check("busy_gap", get_busy(sel), 1'b0);
      end
    end
  endtask

  initial begin
    int rel;
    int target;
    n_tests = 0;
    n_fail  = 0;
    rst_a = 1'b0;
    rst_w = 1'b0;
    rst_z = 1'b0;

    // Reset hold on the default instance.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("rst_txd", txd_a, 1'b1);
      check("rst_busy", busy_a, 1'b0);
      check("rst_char", char_a, 8'h41);
    end

    // Wrap sequence with a three-character range.
    @(negedge clk);
    rel = cyc;
    rst_w = 1'b1;
    exp_q.push_back(8'h30); exp_q.push_back(8'h31); exp_q.push_back(8'h32);
    exp_q.push_back(8'h30); exp_q.push_back(8'h31);
    rx_frames(1, 4, 4, 5, rel);

    // Back-to-back frames with no idle gap.
    @(negedge clk);
    rel = cyc;
    rst_z = 1'b1;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    rx_frames(2, 4, 0, 3, rel);

    // Default parameters: three full frames.
    @(negedge clk);
    rel = cyc;
    rst_a = 1'b1;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    rx_frames(0, DEF_BAUD, DEF_IDLE, 3, rel);

    // Restart, then reset during data bit 3 of the second frame ('B').
    rst_a = 1'b0;
    wait_cycles(5);
    rel = cyc;
    rst_a = 1'b1;
    target = rel + 1 + (10 + DEF_IDLE) * DEF_BAUD + 4 * DEF_BAUD + DEF_BAUD / 2;
    while (cyc < target) @(negedge clk);
    check("mid_frame_bit3", txd_a, 1'b0);
    check("mid_frame_char", char_a, 8'h42);
    rst_a = 1'b0;
    #1;
    check("async_rst_txd", txd_a, 1'b1);
    check("async_rst_busy", busy_a, 1'b0);
    check("async_rst_char", char_a, 8'h41);
    wait_cycles(3);
    rel = cyc;
    rst_a = 1'b1;
    exp_q.push_back(8'h41);
    rx_frames(0, DEF_BAUD, DEF_IDLE, 1, rel);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
